// File: rtl/sram_pkg.sv
// Shared types and constants for the on-chip SRAM model.
package sram_pkg;

  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } sram_state_t;

  // Byte-lane enables are active low; a disabled lane reads as zero.
  function automatic logic [SRAM_DATA_W-1:0] lane_mask(input logic [SRAM_DATA_W-1:0] dat,
                                                        input logic ub_n,
                                                        input logic lb_n);
    lane_mask = {(ub_n ? 8'h00 : dat[15:8]), (lb_n ? 8'h00 : dat[7:0])};
  endfunction

endpackage

// File: rtl/sram_byte_array.sv
// Storage for the SRAM model: 2^DEPTH_LOG2 x 16 words.
// Write lands at the clock edge, read is combinational.
// No backpressure; every enabled write is accepted.
module sram_byte_array
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                   core_clk,
  input  logic                   wr_en,
  input  logic [1:0]             wr_be,
  input  logic [DEPTH_LOG2-1:0]  addr,
  input  logic [SRAM_DATA_W-1:0] wr_dat,
  output logic [SRAM_DATA_W-1:0] rd_dat
);

  logic [SRAM_DATA_W-1:0] mem [2**DEPTH_LOG2];

  // No reset: contents survive a Reset of the responder.
  always_ff @(posedge core_clk) begin
    if (wr_en) begin
      if (wr_be[1]) mem[addr][15:8] <= wr_dat[15:8];
      if (wr_be[0]) mem[addr][7:0]  <= wr_dat[7:0];
    end
  end

  assign rd_dat = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// Synchronous model of the 16-bit async SRAM seen from the arbiter's pins.
// Reads drive data READ_LATENCY edges after the request; writes take one edge.
// No backpressure: any change of CE/OE/WE/address aborts or restarts a read.
module sram_responder
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [SRAM_ADDR_W-1:0] ADDR,
  input  logic                   CE,
  input  logic                   OE,
  input  logic                   WE,
  input  logic                   UB,
  input  logic                   LB,
  input  logic [SRAM_DATA_W-1:0] Data_write,
  output logic [SRAM_DATA_W-1:0] Data_read,
  output logic                   data_drive,
  output logic                   contention,
  output logic                   busy
);

  localparam logic [2:0] LAT_M1 = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

  sram_state_t            state, state_nxt;
  logic [DEPTH_LOG2-1:0]  dec_addr, lat_addr;
  logic [2:0]             wait_cnt;
  logic [SRAM_DATA_W-1:0] rd_dat;
  logic                   is_write, is_read, start_rd;
  logic                   unused_addr_hi;

  assign dec_addr       = ADDR[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^ADDR[SRAM_ADDR_W-1:DEPTH_LOG2];
  assign is_write       = !CE && !WE;
  assign is_read        = !CE && WE && !OE;
  // A read from IDLE or to a new address pays the full latency again.
  assign start_rd       = is_read && ((state == IDLE) || (dec_addr != lat_addr));

  sram_byte_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .core_clk (Clk),
    .wr_en    (is_write),
    .wr_be    ({!UB, !LB}),
    .addr     (dec_addr),
    .wr_dat   (Data_write),
    .rd_dat   (rd_dat)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (is_read) begin
      if (start_rd)              state_nxt = (READ_LATENCY == 0) ? RD_DRIVE : RD_WAIT;
      else if (state == RD_WAIT) state_nxt = (wait_cnt == 3'd0) ? RD_DRIVE : RD_WAIT;
      else                       state_nxt = RD_DRIVE;
    end
  end

  always_comb begin
    data_drive = 1'b0;
    busy       = 1'b0;
    case (state)
      RD_WAIT:  busy       = 1'b1;
      RD_DRIVE: data_drive = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lat_addr   <= '0;
      wait_cnt   <= 3'd0;
      Data_read  <= '0;
      contention <= 1'b0;
    end else begin
      if (start_rd) begin
        lat_addr <= dec_addr;
        wait_cnt <= LAT_M1;
      end else if (state == RD_WAIT && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      // Re-read every driving cycle so the bus reflects current contents.
      Data_read <= (state_nxt == RD_DRIVE) ? lane_mask(rd_dat, UB, LB) : '0;
      if (data_drive && !WE) contention <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboarded bench for sram_responder at default parameters (latency 2, 4K words).
module tb_sram_responder;
  import sram_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [19:0] ADDR;
  logic        CE, OE, WE, UB, LB;
  logic [15:0] Data_write;
  logic [15:0] Data_read;
  logic        data_drive, contention, busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  always #5 Clk = ~Clk;

  sram_responder dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ADDR       (ADDR),
    .CE         (CE),
    .OE         (OE),
    .WE         (WE),
    .UB         (UB),
    .LB         (LB),
    .Data_write (Data_write),
    .Data_read  (Data_read),
    .data_drive (data_drive),
    .contention (contention),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_idle();
    CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
  endtask

  task automatic drive_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    CE = 1'b0; WE = 1'b0; OE = 1'b1; ADDR = a; Data_write = d; UB = ub; LB = lb;
    tick();
    drive_idle();
  endtask

  task automatic drive_read(input logic [19:0] a, input logic ub, input logic lb);
    CE = 1'b0; WE = 1'b1; OE = 1'b0; ADDR = a; UB = ub; LB = lb;
  endtask

  task automatic wait_drive(output int edges, output int busy_cyc, output bit timed_out);
    edges = 0; busy_cyc = 0;
    do begin
      tick();
      edges++;
      if (busy) busy_cyc++;
    end while (!data_drive && edges < 20);
    timed_out = !data_drive;
  endtask

  task automatic test_reset();
    Reset = 1'b1; drive_idle(); ADDR = '0; Data_write = '0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    n_checks++; if (Data_read !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", Data_read); end
    n_checks++; if (data_drive !== 1'b0) begin n_fail++; $display("FAIL reset_drive: got %b want 0", data_drive); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (contention !== 1'b0) begin n_fail++; $display("FAIL reset_contention: got %b want 0", contention); end
  endtask

  task automatic test_basic_rw();
    int e, b; bit to; logic [15:0] exp;
    drive_write(20'h00010, 16'hBEEF, 1'b0, 1'b0);
    drive_read(20'h00010, 1'b0, 1'b0);
    exp_q.push_back(16'hBEEF);
    wait_drive(e, b, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: data_drive never rose"); end
    n_checks++; if (e != 3) begin n_fail++; $display("FAIL basic_latency: got %0d edges want 3", e); end
    n_checks++; if (b != 2) begin n_fail++; $display("FAIL basic_busy: got %0d cycles want 2", b); end
    exp = exp_q.pop_front();
    n_checks++; if (Data_read !== exp) begin n_fail++; $display("FAIL basic_data: got %h want %h", Data_read, exp); end
    tick();
    n_checks++; if (data_drive !== 1'b1 || Data_read !== 16'hBEEF) begin n_fail++; $display("FAIL basic_hold: got %b/%h want 1/beef", data_drive, Data_read); end
    drive_idle();
    tick();
    n_checks++; if (data_drive !== 1'b0) begin n_fail++; $display("FAIL basic_release: got %b want 0", data_drive); end
  endtask

  task automatic test_byte_lanes();
    int e, b; bit to; logic [15:0] exp;
    drive_write(20'h00020, 16'h1234, 1'b0, 1'b0);
    drive_write(20'h00020, 16'hAB00, 1'b0, 1'b1);
    drive_read(20'h00020, 1'b0, 1'b0);
    exp_q.push_back(16'hAB34);
    wait_drive(e, b, to);
    exp = exp_q.pop_front();
    n_checks++; if (to || Data_read !== exp) begin n_fail++; $display("FAIL lane_merge: got %h want %h", Data_read, exp); end
    drive_idle(); tick();
    drive_read(20'h00020, 1'b1, 1'b0);
    exp_q.push_back(16'h0034);
    wait_drive(e, b, to);
    exp = exp_q.pop_front();
    n_checks++; if (to || Data_read !== exp) begin n_fail++; $display("FAIL lane_mask: got %h want %h", Data_read, exp); end
    drive_idle(); tick();
  endtask

  task automatic test_alias();
    int e, b; bit to; logic [15:0] exp;
    drive_write(20'h00003, 16'h5A5A, 1'b0, 1'b0);
    drive_read(20'h01003, 1'b0, 1'b0);
    exp_q.push_back(16'h5A5A);
    wait_drive(e, b, to);
    exp = exp_q.pop_front();
    n_checks++; if (to || Data_read !== exp) begin n_fail++; $display("FAIL alias_data: got %h want %h", Data_read, exp); end
    drive_idle(); tick();
  endtask

  task automatic test_addr_restart();
    int e, b; bit to; logic [15:0] exp;
    drive_read(20'h00010, 1'b0, 1'b0);
    tick(); tick();
    n_checks++; if (data_drive !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_pre: got drive %b busy %b want 0 1", data_drive, busy); end
    ADDR = 20'h00020;
    exp_q.push_back(16'hAB34);
    wait_drive(e, b, to);
    n_checks++; if (e != 3) begin n_fail++; $display("FAIL restart_latency: got %0d edges want 3", e); end
    exp = exp_q.pop_front();
    n_checks++; if (to || Data_read !== exp) begin n_fail++; $display("FAIL restart_data: got %h want %h", Data_read, exp); end
    drive_idle(); tick();
  endtask

  task automatic test_contention();
    int e, b; bit to; logic [15:0] exp;
    drive_write(20'h00030, 16'h1111, 1'b0, 1'b0);
    drive_read(20'h00030, 1'b0, 1'b0);
    wait_drive(e, b, to);
    n_checks++; if (to || contention !== 1'b0) begin n_fail++; $display("FAIL cont_before: got drive %b cont %b want 1 0", data_drive, contention); end
    WE = 1'b0; Data_write = 16'h2222;
    tick();
    n_checks++; if (data_drive !== 1'b0) begin n_fail++; $display("FAIL cont_drop: got %b want 0", data_drive); end
    n_checks++; if (contention !== 1'b1) begin n_fail++; $display("FAIL cont_set: got %b want 1", contention); end
    drive_idle(); tick(); tick();
    drive_read(20'h00030, 1'b0, 1'b0);
    exp_q.push_back(16'h2222);
    wait_drive(e, b, to);
    exp = exp_q.pop_front();
    n_checks++; if (to || Data_read !== exp) begin n_fail++; $display("FAIL cont_write: got %h want %h", Data_read, exp); end
    n_checks++; if (contention !== 1'b1) begin n_fail++; $display("FAIL cont_sticky: got %b want 1", contention); end
    drive_idle(); tick();
  endtask

  task automatic test_reset_midread();
    int e, b; bit to; logic [15:0] exp;
    drive_write(20'h00040, 16'h7777, 1'b0, 1'b0);
    drive_read(20'h00040, 1'b0, 1'b0);
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 1", busy); end
    Reset = 1'b1;
    tick();
    n_checks++; if (Data_read !== 16'h0000 || data_drive !== 1'b0 || busy !== 1'b0 || contention !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_outputs: got %h %b %b %b want 0000 0 0 0", Data_read, data_drive, busy, contention); end
    n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d want %0d", dut.state, IDLE); end
    Reset = 1'b0; drive_idle();
    tick();
    drive_read(20'h00040, 1'b0, 1'b0);
    exp_q.push_back(16'h7777);
    wait_drive(e, b, to);
    exp = exp_q.pop_front();
    n_checks++; if (to || Data_read !== exp) begin n_fail++; $display("FAIL rst_mem_keep: got %h want %h", Data_read, exp); end
    drive_idle(); tick();
    drive_read(20'h00010, 1'b0, 1'b0);
    exp_q.push_back(16'hBEEF);
    wait_drive(e, b, to);
    exp = exp_q.pop_front();
    n_checks++; if (to || Data_read !== exp) begin n_fail++; $display("FAIL rst_mem_old: got %h want %h", Data_read, exp); end
    drive_idle(); tick();
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_byte_lanes();
    test_alias();
    test_addr_restart();
    test_contention();
    test_reset_midread();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synchronous on-chip model of the 16-bit asynchronous SRAM chip that the multi-CPU memory arbiter drives. It sits on the far side of the top-level SRAM pins: it accepts the arbiter's ADDR/CE/OE/WE/UB/LB strobes and write data, and returns read data with a configurable wait-state latency. It also provides a bus-contention monitor. It replaces the external chip in simulation and on-board bring-up, so the arbiter and the tristate split can be exercised with no external part.

## Interface
- DEPTH_LOG2, default 12: word-address bits implemented. Storage is 2^DEPTH_LOG2 × 16.
- READ_LATENCY, default 2: wait cycles inserted before read data is driven. Legal range 0–7.
- Clk  in  1  system clock; all logic updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ADDR  in  20  word address. Only bits [DEPTH_LOG2-1:0] are decoded; upper bits alias.
- CE  in  1  chip enable, active low.
- OE  in  1  output enable, active low.
- WE  in  1  write enable, active low.
- UB  in  1  upper-byte lane enable, active low.
- LB  in  1  lower-byte lane enable, active low.
- Data_write  in  16  write data from the controller-side tristate.
- Data_read  out  16  read data toward the controller-side tristate.
- data_drive  out  1  high while Data_read is valid and the model owns the bus.
- contention  out  1  sticky error flag: model driving while WE low.
- busy  out  1  high while a read is in wait states.

## Operation
- Controls are sampled at every rising edge.
- Request types:
  - Write: CE=0 and WE=0. WE has priority over OE.
  - Read: CE=0, WE=1, OE=0.
  - Otherwise idle.
- FSM states: IDLE, RD_WAIT, RD_DRIVE.
  - IDLE + read, READ_LATENCY>0 → RD_WAIT. Latch the decoded address and load wait_cnt=READ_LATENCY-1.
  - IDLE + read, READ_LATENCY=0 → RD_DRIVE. Data_read takes mem[addr] at the same edge.
  - RD_WAIT: decrement wait_cnt. At 0 → RD_DRIVE and load Data_read. busy=1 throughout RD_WAIT.
  - RD_DRIVE: data_drive=1. Data_read re-reads the latched address every cycle, so it tracks same-address writes.
  - Any state, decoded ADDR differs from the latched address during a read → return to RD_WAIT/RD_DRIVE with the new address and a full latency restart.
  - Any state, CE=1 or OE=1 sampled → IDLE; data_drive=0 at that edge.
  - Any state, write sampled → IDLE and the write is performed.
- Write behaviour:
  - Per-lane write: UB=0 writes bits [15:8] and LB=0 writes bits [7:0] at the sampling edge.
  - UB=LB=1 with WE=0 is a no-op write.
  - Write completes in one cycle. A held WE=0 rewrites every cycle.
- Read lane masking: a lane whose enable is high reads as 8'h00 on Data_read.
- Address aliasing: ADDR[19:DEPTH_LOG2] are ignored, so addresses wrap modulo 2^DEPTH_LOG2.
- Contention: contention sets when data_drive=1 and WE=0 are sampled together. It clears only on Reset.
- Memory contents are not cleared by Reset and are undefined after power-up.

## Timing
- Reset values:
  - Data_read=16'h0000, data_drive=0, busy=0, contention=0, state=IDLE, wait_cnt=0.
  - Reset during a read aborts it at that edge; no data is driven afterwards.
- Read latency: a read sampled at edge k makes Data_read valid and data_drive=1 after edge k+READ_LATENCY.
  - With READ_LATENCY=0, valid after edge k.
  - Data stays valid until the edge that samples OE=1, CE=1, a write, or an address change.
- Write-to-read: a write at edge k is visible to a read sampled at edge k+1.
- Back-to-back reads to different addresses each pay the full READ_LATENCY. There is no pipelining.
- Simultaneous OE=0 and WE=0: the access is a write. data_drive drops at that edge, and contention sets if data_drive was 1 before the edge.

## Structure
- Shared package sram_pkg holds:
  - the state enum sram_state_t {IDLE, RD_WAIT, RD_DRIVE};
  - the constants SRAM_DATA_W=16 and SRAM_ADDR_W=20.
- Sub-module sram_byte_array holds the storage: 2^DEPTH_LOG2 × 16, synchronous write with two byte enables, combinational read. The FSM, counter and contention logic stay in sram_responder.

## Test plan
- Reset, then write 16'hBEEF to ADDR 20'h00010 with UB=LB=0, then read the same address with OE=0 → data_drive rises after READ_LATENCY edges and Data_read=16'hBEEF; busy=1 for exactly 2 cycles at default latency.
- Write 16'h1234 to 20'h00020, then write 16'hAB00 with UB=0, LB=1 → a read returns 16'hAB34; a read with UB=1, LB=0 returns 16'h0034.
- Write 16'h5A5A to 20'h00003, then read 20'h01003 (aliases when DEPTH_LOG2=12) → Data_read=16'h5A5A.
- Read 20'h00010 and change ADDR to 20'h00020 one cycle before data is due → latency restarts, and data_drive first rises with mem[20'h00020]; the old word is never driven.
- While in RD_DRIVE, assert WE=0 with OE=0 → data_drive=0 after that edge, the write is performed, and contention=1 and stays set until Reset.
- Assert Reset during RD_WAIT → all outputs read 0 after the edge and the state is IDLE; memory contents written earlier are still readable after Reset is released.
